// File: rtl/main_memory_burst.sv
// Block-oriented main memory: one request moves a whole BLOCK_WORDS block,
// reads after a fixed latency (optionally critical-word-first), writes sequentially.
module main_memory_burst #(
  parameter int WORD_LENGTH = 32,
  parameter int ADDR_WIDTH  = 15,
  parameter int BLOCK_WORDS = 4,
  parameter int LATENCY     = 4,
  parameter int WRAP_MODE   = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [WORD_LENGTH-1:0] wr_data,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [WORD_LENGTH-1:0] resp_data,
  output logic                   resp_last,
  output logic                   wr_done,
  output logic                   busy
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int OBITS = $clog2(BLOCK_WORDS);
  localparam int BBITS = ADDR_WIDTH - OBITS;
  localparam int CBITS = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam logic [OBITS-1:0] LAST_BEAT = OBITS'(BLOCK_WORDS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_BURST = 2'd2;
  localparam logic [1:0] S_WRITE = 2'd3;

  logic [1:0]             state_q, state_d;
  logic [BBITS-1:0]       base_q, base_d;
  logic [OBITS-1:0]       off_q, off_d;
  logic [OBITS-1:0]       beat_q, beat_d;
  logic [CBITS-1:0]       lat_q, lat_d;
  logic                   wr_done_q, wr_done_d;

  logic [WORD_LENGTH-1:0] mem_q [DEPTH];
  // Words never written read back as their own address, so no RAM preload is needed.
  bit                     written_q [DEPTH] = '{default: 1'b0};

  logic [OBITS-1:0]       rd_idx;
  logic [ADDR_WIDTH-1:0]  rd_addr;
  logic [ADDR_WIDTH-1:0]  wr_addr;
  logic [WORD_LENGTH-1:0] rd_word;
  logic                   wr_fire;

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    off_d     = off_q;
    beat_d    = beat_q;
    lat_d     = lat_q;
    wr_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          base_d = req_addr[ADDR_WIDTH-1:OBITS];
          off_d  = req_addr[OBITS-1:0];
          beat_d = '0;
          if (req_write) begin
            state_d = S_WRITE;
          end else if (LATENCY == 1) begin
            state_d = S_BURST;
          end else begin
            state_d = S_WAIT;
            lat_d   = CBITS'(LATENCY - 2);
          end
        end
      end
      S_WAIT: begin
        if (lat_q == '0) begin
          state_d = S_BURST;
        end else begin
          lat_d = lat_q - CBITS'(1);
        end
      end
      S_BURST: begin
        if (resp_ready) begin
          beat_d = beat_q + OBITS'(1);
          if (beat_q == LAST_BEAT) begin
            state_d = S_IDLE;
          end
        end
      end
      S_WRITE: begin
        if (wr_valid) begin
          beat_d = beat_q + OBITS'(1);
          if (beat_q == LAST_BEAT) begin
            state_d   = S_IDLE;
            wr_done_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      base_q    <= '0;
      off_q     <= '0;
      beat_q    <= '0;
      lat_q     <= '0;
      wr_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      off_q     <= off_d;
      beat_q    <= beat_d;
      lat_q     <= lat_d;
      wr_done_q <= wr_done_d;
    end
  end

  // The beat index is concatenated under the base, so offsets can never carry out of the block.
  assign rd_idx  = (WRAP_MODE != 0) ? (off_q + beat_q) : beat_q;
  assign rd_addr = {base_q, rd_idx};
  assign wr_addr = {base_q, beat_q};
  assign wr_fire = (state_q == S_WRITE) && wr_valid && !rst;

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_q[wr_addr]     <= wr_data;
      written_q[wr_addr] <= 1'b1;
    end
  end

  assign rd_word = written_q[rd_addr] ? mem_q[rd_addr] : WORD_LENGTH'(rd_addr);

  assign req_ready  = (state_q == S_IDLE);
  assign wr_ready   = (state_q == S_WRITE);
  assign resp_valid = (state_q == S_BURST);
  assign resp_last  = resp_valid && (beat_q == LAST_BEAT);
  assign resp_data  = resp_valid ? rd_word : '0;
  assign wr_done    = wr_done_q;
  assign busy       = (state_q != S_IDLE);

endmodule
